// File: rtl/ctrl_pipe.sv
// ctrl_pipe - control unit for the 5-stage RISC-V core.
//
// Decodes the ID-stage opcode into the control bundle. The bundle and the
// destination register index then pass through the ID/EX, EX/MEM and MEM/WB
// control registers. The block also provides:
//   - load-use hazard detection (stall plus bubble insertion),
//   - branch flush of the ID-stage instruction,
//   - a saturating stall-cycle counter for performance monitoring.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-low reset
//   opcode_i, rs1_i,      ID-stage instruction fields
//   rs2_i, rd_i
//   flush_i               kill the ID-stage instruction (branch taken)
//   id_branch_o, stall_o  combinational ID-stage outputs
//   ex_*                  ID/EX control register outputs
//   mem_*                 EX/MEM control register outputs
//   wb_*                  MEM/WB control register outputs
//   stall_cnt_o           saturating count of stall cycles
module ctrl_pipe #(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16,
  parameter bit EN_HAZARD = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             flush_i,
  output logic             id_branch_o,
  output logic             stall_o,
  output logic [1:0]       ex_alu_op_o,
  output logic             ex_alu_src_o,
  output logic             ex_mem_read_o,
  output logic [REG_W-1:0] ex_rd_o,
  output logic             mem_mem_read_o,
  output logic             mem_mem_write_o,
  output logic             mem_reg_write_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic             wb_reg_write_o,
  output logic             wb_mem_to_reg_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  // Per-stage control bundles. Each stage keeps only the fields that are
  // still consumed downstream of it.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } ex_ctl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctl_t;

  ex_ctl_t          dec_ctl;
  logic             dec_branch;
  logic             dec_rs2_used;

  ex_ctl_t          ex_ctl;
  logic [REG_W-1:0] ex_rd;
  mem_ctl_t         mem_ctl;
  logic [REG_W-1:0] mem_rd;
  wb_ctl_t          wb_ctl;
  logic [REG_W-1:0] wb_rd;
  logic [CNT_W-1:0] stall_cnt;

  logic             hazard;

  // ---------------------------------------------------------------------
  // ID-stage decode
  // ---------------------------------------------------------------------
  always_comb begin
    dec_ctl      = '0;
    dec_branch   = 1'b0;
    dec_rs2_used = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        dec_ctl.alu_op    = 2'b10;
        dec_ctl.reg_write = 1'b1;
        dec_rs2_used      = 1'b1;
      end
      OP_IARITH: begin
        dec_ctl.alu_op    = 2'b10;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec_ctl.alu_src    = 1'b1;
        dec_ctl.mem_read   = 1'b1;
        dec_ctl.reg_write  = 1'b1;
        dec_ctl.mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.mem_write = 1'b1;
        dec_rs2_used      = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctl.alu_op = 2'b01;
        dec_branch     = 1'b1;
        dec_rs2_used   = 1'b1;
      end
      OP_NOP: ;  // bubble encoding: all-zero control, not illegal
      default: dec_ctl.illegal = 1'b1;
    endcase
    // x0 is hardwired; a write to it must not appear as a forwarding source.
    if (rd_i == '0) dec_ctl.reg_write = 1'b0;
  end

  // ---------------------------------------------------------------------
  // Load-use hazard: the load in EX has not produced data yet, so an ID
  // instruction reading its rd must wait one cycle. rs2 only matters for
  // formats that actually read it; the rs2 field of I-type holds immediate
  // bits and must not cause a false stall.
  // ---------------------------------------------------------------------
  always_comb begin
    hazard = 1'b0;
    if (ex_ctl.mem_read && (ex_rd != '0)) begin
      if ((ex_rd == rs1_i) || ((ex_rd == rs2_i) && dec_rs2_used))
        hazard = 1'b1;
    end
  end

  assign stall_o     = EN_HAZARD ? hazard : 1'b0;
  assign id_branch_o = dec_branch & ~stall_o;

  // ---------------------------------------------------------------------
  // Pipeline control registers. Only ID/EX sees flush and stall; the
  // later stages advance every cycle, so a bubble drains naturally.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_ctl  <= '0;
      ex_rd   <= '0;
      mem_ctl <= '0;
      mem_rd  <= '0;
      wb_ctl  <= '0;
      wb_rd   <= '0;
    end else begin
      if (flush_i || stall_o) begin
        ex_ctl <= '0;
        ex_rd  <= '0;
      end else begin
        ex_ctl <= dec_ctl;
        ex_rd  <= rd_i;
      end

      mem_ctl.mem_read   <= ex_ctl.mem_read;
      mem_ctl.mem_write  <= ex_ctl.mem_write;
      mem_ctl.reg_write  <= ex_ctl.reg_write;
      mem_ctl.mem_to_reg <= ex_ctl.mem_to_reg;
      mem_rd             <= ex_rd;

      wb_ctl.reg_write   <= mem_ctl.reg_write;
      wb_ctl.mem_to_reg  <= mem_ctl.mem_to_reg;
      wb_rd              <= mem_rd;
    end
  end

  // ---------------------------------------------------------------------
  // Stall counter: counts every edge with stall_o high, including cycles
  // where a simultaneous flush decides what enters EX. Holds at all-ones.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      stall_cnt <= '0;
    else if (stall_o && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign ex_alu_op_o     = ex_ctl.alu_op;
  assign ex_alu_src_o    = ex_ctl.alu_src;
  assign ex_mem_read_o   = ex_ctl.mem_read;
  assign ex_rd_o         = ex_rd;
  assign ex_illegal_o    = ex_ctl.illegal;
  assign mem_mem_read_o  = mem_ctl.mem_read;
  assign mem_mem_write_o = mem_ctl.mem_write;
  assign mem_reg_write_o = mem_ctl.reg_write;
  assign mem_rd_o        = mem_rd;
  assign wb_reg_write_o  = wb_ctl.reg_write;
  assign wb_mem_to_reg_o = wb_ctl.mem_to_reg;
  assign wb_rd_o         = wb_rd;
  assign stall_cnt_o     = stall_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe - directed bench for ctrl_pipe (CNT_W=2 so saturation is
// reachable in a short run).
module tb_ctrl_pipe;

  localparam int REG_W = 5;
  localparam int CNT_W = 2;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] NP = 7'b0000000;
  localparam logic [6:0] IL = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [6:0]       opcode_i;
  logic [REG_W-1:0] rs1_i, rs2_i, rd_i;
  logic             flush_i;
  logic             id_branch_o, stall_o;
  logic [1:0]       ex_alu_op_o;
  logic             ex_alu_src_o, ex_mem_read_o;
  logic [REG_W-1:0] ex_rd_o;
  logic             mem_mem_read_o, mem_mem_write_o, mem_reg_write_o;
  logic [REG_W-1:0] mem_rd_o;
  logic             wb_reg_write_o, wb_mem_to_reg_o;
  logic [REG_W-1:0] wb_rd_o;
  logic             ex_illegal_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W), .EN_HAZARD(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .id_branch_o(id_branch_o), .stall_o(stall_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_rd_o(ex_rd_o),
    .mem_mem_read_o(mem_mem_read_o), .mem_mem_write_o(mem_mem_write_o),
    .mem_reg_write_o(mem_reg_write_o), .mem_rd_o(mem_rd_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .wb_rd_o(wb_rd_o), .ex_illegal_o(ex_illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [REG_W-1:0] s1,
                        input logic [REG_W-1:0] s2, input logic [REG_W-1:0] d);
    opcode_i = op; rs1_i = s1; rs2_i = s2; rd_i = d;
    #1;
  endtask

  task automatic check_ex_zero(input string tag);
    check({tag, ".alu_op"},   32'(ex_alu_op_o),   32'd0);
    check({tag, ".alu_src"},  32'(ex_alu_src_o),  32'd0);
    check({tag, ".mem_read"}, 32'(ex_mem_read_o), 32'd0);
    check({tag, ".rd"},       32'(ex_rd_o),       32'd0);
    check({tag, ".illegal"},  32'(ex_illegal_o),  32'd0);
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0;
    set_id(LD, 5'd1, 5'd2, 5'd7);

    // Reset with a load sitting in ID.
    tick(); tick();
    check_ex_zero("rst.ex");
    check("rst.mem_rd",   32'(mem_mem_read_o),  32'd0);
    check("rst.mem_wr",   32'(mem_mem_write_o), 32'd0);
    check("rst.mem_rw",   32'(mem_reg_write_o), 32'd0);
    check("rst.mem_rdi",  32'(mem_rd_o),        32'd0);
    check("rst.wb_rw",    32'(wb_reg_write_o),  32'd0);
    check("rst.wb_m2r",   32'(wb_mem_to_reg_o), 32'd0);
    check("rst.wb_rdi",   32'(wb_rd_o),         32'd0);
    check("rst.cnt",      32'(stall_cnt_o),     32'd0);
    check("rst.stall",    32'(stall_o),         32'd0);

    // First edge after release latches the load decode.
    rst_i = 1'b1;
    tick();
    check("ld.ex_mr",  32'(ex_mem_read_o), 32'd1);
    check("ld.ex_src", 32'(ex_alu_src_o),  32'd1);
    check("ld.ex_rd",  32'(ex_rd_o),       32'd7);

    // R-type rd=5 through the pipe (load rd=7 one stage ahead).
    set_id(R, 5'd1, 5'd2, 5'd5);
    check("rt.nostall", 32'(stall_o), 32'd0);
    tick();
    set_id(NP, 5'd0, 5'd0, 5'd0);
    check("rt.ex_op",  32'(ex_alu_op_o),    32'd2);
    check("rt.ex_src", 32'(ex_alu_src_o),   32'd0);
    check("rt.ex_rd",  32'(ex_rd_o),        32'd5);
    check("ld.mem_mr", 32'(mem_mem_read_o), 32'd1);
    check("ld.mem_rd", 32'(mem_rd_o),       32'd7);
    tick();
    check("rt.mem_rw", 32'(mem_reg_write_o), 32'd1);
    check("rt.mem_rd", 32'(mem_rd_o),        32'd5);
    check("rt.mem_mr", 32'(mem_mem_read_o),  32'd0);
    check("ld.wb_m2r", 32'(wb_mem_to_reg_o), 32'd1);
    check("ld.wb_rd",  32'(wb_rd_o),         32'd7);
    tick();
    check("rt.wb_rw",  32'(wb_reg_write_o),  32'd1);
    check("rt.wb_m2r", 32'(wb_mem_to_reg_o), 32'd0);
    check("rt.wb_rd",  32'(wb_rd_o),         32'd5);

    // Load-use on rs2: one stall, one bubble, then the R-type.
    set_id(LD, 5'd1, 5'd0, 5'd3);
    tick();
    set_id(R, 5'd6, 5'd3, 5'd8);
    check("lu.stall", 32'(stall_o), 32'd1);
    tick();
    check_ex_zero("lu.bubble");
    check("lu.cnt",    32'(stall_cnt_o), 32'd1);
    check("lu.unstall", 32'(stall_o),    32'd0);
    tick();
    check("lu.ex_op", 32'(ex_alu_op_o), 32'd2);
    check("lu.ex_rd", 32'(ex_rd_o),      32'd8);

    // Branch in ID behind a dependent load is masked while stalled.
    set_id(LD, 5'd0, 5'd0, 5'd3);
    tick();
    set_id(BR, 5'd3, 5'd9, 5'd0);
    check("brm.stall",  32'(stall_o),     32'd1);
    check("brm.branch", 32'(id_branch_o), 32'd0);
    tick();
    check("brm.cnt", 32'(stall_cnt_o), 32'd2);

    // No false stall: load to x0, then I-arith with rs2 field matching.
    set_id(LD, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(R, 5'd0, 5'd0, 5'd6);
    check("nf.x0", 32'(stall_o), 32'd0);
    set_id(LD, 5'd1, 5'd0, 5'd4);
    tick();
    set_id(IA, 5'd1, 5'd4, 5'd9);
    check("nf.irs2", 32'(stall_o), 32'd0);
    set_id(ST, 5'd1, 5'd4, 5'd0);
    check("nf.st_rs2", 32'(stall_o), 32'd1);
    set_id(IA, 5'd1, 5'd4, 5'd9);
    tick();
    check("nf.cnt", 32'(stall_cnt_o), 32'd2);

    // Flush: branch, then a flushed store.
    set_id(BR, 5'd1, 5'd2, 5'd0);
    check("fl.branch", 32'(id_branch_o), 32'd1);
    tick();
    check("fl.ex_op", 32'(ex_alu_op_o), 32'd1);
    set_id(ST, 5'd1, 5'd2, 5'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_id(NP, 5'd0, 5'd0, 5'd0);
    check_ex_zero("fl.ex");
    tick();
    check("fl.mem_wr", 32'(mem_mem_write_o), 32'd0);
    tick();
    check("fl.mem_wr2", 32'(mem_mem_write_o), 32'd0);

    // Illegal opcode for exactly one cycle.
    set_id(IL, 5'd0, 5'd0, 5'd5);
    tick();
    set_id(NP, 5'd0, 5'd0, 5'd0);
    check("il.flag",   32'(ex_illegal_o),  32'd1);
    check("il.op",     32'(ex_alu_op_o),   32'd0);
    check("il.src",    32'(ex_alu_src_o),  32'd0);
    check("il.mr",     32'(ex_mem_read_o), 32'd0);
    tick();
    check("il.clear",  32'(ex_illegal_o),    32'd0);
    check("il.mem_rw", 32'(mem_reg_write_o), 32'd0);
    check("il.mem_wr", 32'(mem_mem_write_o), 32'd0);

    // Flush and stall together: flush wins, counter still counts.
    set_id(LD, 5'd0, 5'd0, 5'd3);
    tick();
    set_id(R, 5'd3, 5'd0, 5'd8);
    flush_i = 1'b1;
    check("fs.stall", 32'(stall_o), 32'd1);
    tick();
    flush_i = 1'b0;
    check_ex_zero("fs.ex");
    check("fs.cnt", 32'(stall_cnt_o), 32'd3);

    // Reset in the middle of a stall clears pipeline and counter.
    set_id(LD, 5'd0, 5'd0, 5'd3);
    tick();
    set_id(R, 5'd3, 5'd0, 5'd8);
    check("rs.stall", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    tick();
    check("rs.ex_mr", 32'(ex_mem_read_o), 32'd0);
    check("rs.cnt",   32'(stall_cnt_o),   32'd0);
    check("rs.stall_drop", 32'(stall_o),  32'd0);
    rst_i = 1'b1;

    // Five stall cycles with a 2-bit counter: holds at 3.
    for (int i = 0; i < 5; i++) begin
      set_id(LD, 5'd0, 5'd0, 5'd1);
      tick();
      set_id(R, 5'd1, 5'd0, 5'd2);
      check("sat.stall", 32'(stall_o), 32'd1);
      tick();
    end
    check("sat.cnt", 32'(stall_cnt_o), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
